// File: rtl/ibex_instr_arb_pkg.sv
// Shared types and constants for the instruction-bus arbiter slice.
//   MAX_PORTS : upper bound on the number of requesting hosts
//   ADDR_W    : instruction word-address width
//   arb_id_t  : source ID wide enough for MAX_PORTS hosts
//   arb_cnt_t : outstanding-transaction counter
package ibex_instr_arb_pkg;

  localparam int MAX_PORTS = 4;
  localparam int ADDR_W    = 32;
  localparam int CNT_W     = 4;

  typedef logic [1:0]       arb_id_t;
  typedef logic [CNT_W-1:0] arb_cnt_t;

endpackage

// File: rtl/ibex_instr_arb_id_fifo.sv
// Circular FIFO of source IDs for granted-but-unanswered transactions.
// The head entry names the host that owns the next in-order response.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i/push_id_i  enqueue an ID (ignored when full)
//   pop_i          dequeue the head (ignored when empty)
//   head_id_o      ID at the head of the queue
//   empty_o/full_o occupancy flags
//   count_o        number of stored IDs
module ibex_instr_arb_id_fifo
  import ibex_instr_arb_pkg::*;
#(
  parameter int Depth = 2,
  parameter int IdW   = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  logic [IdW-1:0] push_id_i,
  input  logic           pop_i,
  output logic [IdW-1:0] head_id_o,
  output logic           empty_o,
  output logic           full_o,
  output arb_cnt_t       count_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [IdW-1:0]  mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] wr_ptr_q;
  arb_cnt_t        count_q;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == arb_cnt_t'(Depth));
  assign count_o   = count_q;
  assign head_id_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ibex_instr_bus_arbiter.sv
// Shares one instruction-memory req/gnt/rvalid bus between NumPorts hosts
// (2..4). Port 0 is the core prefetch buffer, port 1 a secondary reader.
// Build option: define IBEX_INSTR_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins); otherwise arbitration is round-robin.
// Ports:
//   clk_i, rst_i                clock, asynchronous active-high reset
//   host_req_i/host_gnt_o       per-host request / zero-cycle grant
//   host_addr_i                 per-host word address, host i at [32i+:32]
//   host_rvalid_o               per-host response valid (in grant order)
//   host_rdata_o/host_err_o     response data/error, broadcast
//   instr_*                     downstream instruction bus
//   busy_o                      transactions outstanding or request pending
//   spurious_rvalid_o           sticky: rvalid seen with nothing outstanding
//
// Handshake: a host raises req with a stable addr and holds both until the
// cycle its gnt is high; that cycle is the transfer. Downstream follows the
// same req/gnt rule. Every granted transfer receives exactly one rvalid,
// in grant order, some cycles later; rvalid has no back-pressure.
module ibex_instr_bus_arbiter
  import ibex_instr_arb_pkg::*;
#(
  parameter int NumPorts       = 2,
  parameter int MaxOutstanding = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumPorts-1:0]        host_req_i,
  output logic [NumPorts-1:0]        host_gnt_o,
  input  logic [NumPorts*ADDR_W-1:0] host_addr_i,
  output logic [NumPorts-1:0]        host_rvalid_o,
  output logic [31:0]                host_rdata_o,
  output logic                       host_err_o,
  output logic                       instr_req_o,
  input  logic                       instr_gnt_i,
  output logic [ADDR_W-1:0]          instr_addr_o,
  input  logic                       instr_rvalid_i,
  input  logic [31:0]                instr_rdata_i,
  input  logic                       instr_err_i,
  output logic                       busy_o,
  output logic                       spurious_rvalid_o
);

  localparam int IdW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic           lock_q;
  logic [IdW-1:0] locked_id_q;
  logic [IdW-1:0] sel;
  logic [IdW-1:0] sel_unlocked;
  logic           grant;
  logic           spurious_q;
  logic [IdW-1:0] head_id;
  logic           fifo_empty;
  logic           fifo_full;
  arb_cnt_t       fifo_count;

`ifdef IBEX_INSTR_ARB_FIXED_PRIO_EN
  // Lowest requesting index wins.
  always_comb begin
    logic found;
    found        = 1'b0;
    sel_unlocked = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (!found && host_req_i[i]) begin
        sel_unlocked = IdW'(i);
        found        = 1'b1;
      end
    end
  end
`else
  logic [IdW-1:0] rr_ptr_q;

  // Scan from rr_ptr_q upward with wrap; with no requester the pointer
  // itself is selected so the idle address is still well defined.
  always_comb begin
    logic found;
    int   idx;
    found        = 1'b0;
    idx          = 0;
    sel_unlocked = rr_ptr_q;
    for (int j = 0; j < NumPorts; j++) begin
      idx = int'(rr_ptr_q) + j;
      if (idx >= NumPorts) begin
        idx = idx - NumPorts;
      end
      if (!found && host_req_i[idx]) begin
        sel_unlocked = IdW'(idx);
        found        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else if (grant) begin
      rr_ptr_q <= (sel == IdW'(NumPorts - 1)) ? '0 : sel + 1'b1;
    end
  end
`endif

  // A request that is offered but not granted keeps its host selected so
  // the downstream address never changes under a pending request.
  assign sel = lock_q ? locked_id_q : sel_unlocked;

  // The tracker occupancy is registered, so there is no combinational path
  // from instr_rvalid_i into instr_req_o.
  assign instr_req_o  = host_req_i[sel] & ~fifo_full;
  assign instr_addr_o = host_addr_i[ADDR_W*int'(sel) +: ADDR_W];
  assign grant        = instr_req_o & instr_gnt_i;

  always_comb begin
    host_gnt_o      = '0;
    host_gnt_o[sel] = grant;
  end

  // While full, instr_req_o is low so neither the set nor the clear-on-grant
  // branch fires and an existing lock is simply held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q      <= 1'b0;
      locked_id_q <= '0;
    end else if (instr_req_o && !instr_gnt_i) begin
      lock_q      <= 1'b1;
      locked_id_q <= sel;
    end else if (grant) begin
      lock_q <= 1'b0;
    end else if (lock_q && !host_req_i[locked_id_q]) begin
      // Locked host withdrew its request; release rather than wedge.
      lock_q <= 1'b0;
    end
  end

  ibex_instr_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .IdW   (IdW)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (grant),
    .push_id_i (sel),
    .pop_i     (instr_rvalid_i),
    .head_id_o (head_id),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (fifo_count)
  );

  always_comb begin
    host_rvalid_o = '0;
    if (instr_rvalid_i && !fifo_empty) begin
      host_rvalid_o[head_id] = 1'b1;
    end
  end

  assign host_rdata_o = instr_rdata_i;
  assign host_err_o   = instr_err_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spurious_q <= 1'b0;
    end else if (instr_rvalid_i && fifo_empty) begin
      spurious_q <= 1'b1;
    end
  end

  assign spurious_rvalid_o = spurious_q;
  assign busy_o            = (fifo_count != '0) | instr_req_o;

endmodule
